call_dispatcher: RTL

Queues floor-panel trip requests (origin, destination) and issues them one at a time to the elevator controller's request interface. It is the initiator for the controller's `en`/`in_origin`/`destination`/`idle` handshake. Each request is held stable at the head of the queue until the controller reports the trip complete. It sits between the floor-panel call logic and the elevator controller.

---
 rtl/elevator_pkg.sv | 25 ++
 rtl/call_fifo.sv | 60 ++++++
 rtl/call_dispatcher.sv | 134 +++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator types: floor encoding, dispatcher state and queued call record.
package elevator_pkg;

    localparam int NUM_FLOORS = 5;

    typedef logic [2:0] floor_t;

    typedef enum logic [1:0] {
        READY,
        ISSUE,
        WAIT_ACK,
        TRIP
    } disp_state_t;

    typedef struct packed {
        floor_t origin;
        floor_t dest;
    } call_t;

    // A call is serviceable only between two distinct, existing floors.
    function automatic logic call_is_valid(floor_t origin, floor_t dest);
        return (int'(origin) < NUM_FLOORS) && (int'(dest) < NUM_FLOORS) && (origin != dest);
    endfunction

endpackage

// File: rtl/call_fifo.sv
// DEPTH-entry FIFO of trip requests; the head stays put until popped.
module call_fifo
    import elevator_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  call_t         push_data,
    input  logic          pop,
    output call_t         head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    call_t         mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage needs no reset: an empty queue masks the head to zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = empty ? call_t'('0) : mem[rd_ptr];

endmodule

// File: rtl/call_dispatcher.sv
// Queues panel calls and issues them one at a time to the elevator controller.
// state    | meaning
// READY    | waiting for a queued call and an idle controller
// ISSUE    | req_en strobe for one cycle
// WAIT_ACK | waiting for the controller to drop idle; times out and re-issues
// TRIP     | trip in progress; head held until idle returns, then popped
module call_dispatcher
    import elevator_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 16,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          call_valid,
    input  floor_t        call_origin,
    input  floor_t        call_dest,
    output logic          call_ready,
    input  logic          elev_idle,
    output logic          req_en,
    output floor_t        req_origin,
    output floor_t        req_dest,
    output logic [CW-1:0] queue_count,
    output logic [7:0]    drop_count,
    output logic [7:0]    retry_count
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    disp_state_t   state;
    logic [TW-1:0] ack_timer;
    call_t         head;
    call_t         new_call;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;
    logic          fifo_full;
    logic          fifo_empty;
    logic          accept;
    logic          call_ok;
    logic          push;
    logic          pop;

    assign new_call.origin = call_origin;
    assign new_call.dest   = call_dest;

    assign accept = call_valid && call_ready;
    assign call_ok = call_is_valid(call_origin, call_dest);
    assign push   = accept && call_ok && !fifo_full;
    assign pop    = (state == TRIP) && elev_idle && !fifo_empty;

    call_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (new_call),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign queue_count = fifo_count;
    assign req_origin  = head.origin;
    assign req_dest    = head.dest;

    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + CW'(1);
        end else if (pop && !push) begin
            count_next = fifo_count - CW'(1);
        end
    end

    // call_ready tracks the occupancy that will exist after this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            call_ready <= 1'b1;
            drop_count <= '0;
        end else begin
            call_ready <= (count_next < CW'(DEPTH));
            if (accept && !call_ok && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= READY;
            req_en      <= 1'b0;
            ack_timer   <= '0;
            retry_count <= '0;
        end else begin
            case (state)
                READY: begin
                    if ((fifo_count != '0) && elev_idle) begin
                        state  <= ISSUE;
                        req_en <= 1'b1;
                    end
                end
                ISSUE: begin
                    state     <= WAIT_ACK;
                    req_en    <= 1'b0;
                    ack_timer <= '0;
                end
                WAIT_ACK: begin
                    if (!elev_idle) begin
                        state <= TRIP;
                    end else if (ack_timer == TW'(ACK_TIMEOUT - 1)) begin
                        state <= READY;
                        if (retry_count != 8'hFF) begin
                            retry_count <= retry_count + 8'd1;
                        end
                    end else begin
                        ack_timer <= ack_timer + TW'(1);
                    end
                end
                TRIP: begin
                    if (elev_idle) begin
                        state <= READY;
                    end
                end
                default: begin
                    state  <= READY;
                    req_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
